opp_m_ctrl: RTL and testbench

OPP_M_CTRL -- requirements
Module: opp_m_ctrl

---
 rtl/opp_m_ctrl.sv | 169 ++++++++++++++++
 tb/tb_opp_m_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/opp_m_ctrl.sv
// ---------------------------------------------------------------------------
// opp_m_ctrl
//
// Sequences a ROWS x ROW_W matrix, one row per cycle, through an external row
// datapath. It collects the datapath results after a fixed latency and
// publishes the complete result matrix in one step. The block does no
// arithmetic on row data: results are stored bit-exact.
//
// Parameters
//   ROWS    number of rows per operation
//   ROW_W   row width in bits (row 0 lives in the MSB slice of the matrices)
//   DP_LAT  datapath latency, dp_row -> dp_res, in cycles (1..4)
//
// Ports
//   clk       clock; all state changes on the rising edge
//   rst       asynchronous reset, active low
//   start     request one operation; only looked at while idle
//   m_in      source matrix, latched on the accepting edge
//   dp_row    row being issued to the datapath (zero when not issuing)
//   dp_valid  high while dp_row carries an issued row
//   dp_res    datapath result, DP_LAT cycles behind dp_row
//   m_out     result matrix; held between operations
//   busy      high while issuing or draining
//   done      one-cycle pulse in the cycle m_out has just been updated
// ---------------------------------------------------------------------------
module opp_m_ctrl #(
    parameter int ROWS   = 5,
    parameter int ROW_W  = 40,
    parameter int DP_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ROWS*ROW_W-1:0] m_in,
    output logic [ROW_W-1:0]      dp_row,
    output logic                  dp_valid,
    input  logic [ROW_W-1:0]      dp_res,
    output logic [ROWS*ROW_W-1:0] m_out,
    output logic                  busy,
    output logic                  done
);

    localparam int MAT_W = ROWS * ROW_W;
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [ROW_W-1:0]   shadow_q [ROWS];
    logic [ROW_W-1:0]   res_q    [ROWS];
    logic [IDX_W-1:0]   issue_idx_q;
    logic [IDX_W-1:0]   cap_idx_q;
    logic [DP_LAT-1:0]  vpipe_q;
    logic [ROW_W-1:0]   dp_row_q;
    logic               dp_valid_q;
    logic [MAT_W-1:0]   m_out_q;
    logic               busy_q;
    logic               done_q;

    // Row views of the input matrix, and the result buffer with the row being
    // captured this cycle merged in. The merged view lets m_out load the
    // whole matrix, final row included, on the same edge that captures that
    // final row.
    logic [ROW_W-1:0]   m_in_row [ROWS];
    logic [MAT_W-1:0]   res_merged;
    logic [DP_LAT:0]    vpipe_ext;
    logic               cap_en;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
            assign m_in_row[gi] = m_in[(ROWS-1-gi)*ROW_W +: ROW_W];
            assign res_merged[(ROWS-1-gi)*ROW_W +: ROW_W] =
                (cap_idx_q == IDX_W'(gi)) ? dp_res : res_q[gi];
        end
    endgenerate

    // Valid delay line: bit DP_LAT-1 is high in the cycle where dp_res
    // carries the result of a row issued DP_LAT cycles earlier.
    assign vpipe_ext = {vpipe_q, dp_valid_q};
    assign cap_en    = vpipe_q[DP_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            issue_idx_q <= '0;
            cap_idx_q   <= '0;
            vpipe_q     <= '0;
            dp_row_q    <= '0;
            dp_valid_q  <= 1'b0;
            m_out_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                shadow_q[i] <= '0;
                res_q[i]    <= '0;
            end
        end else begin
            vpipe_q <= vpipe_ext[DP_LAT-1:0];
            done_q  <= 1'b0;

            if (cap_en) begin
                res_q[cap_idx_q] <= dp_res;
                cap_idx_q        <= cap_idx_q + IDX_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < ROWS; i++) begin
                            shadow_q[i] <= m_in_row[i];
                        end
                        issue_idx_q <= '0;
                        cap_idx_q   <= '0;
                        // Row 0 goes out straight from m_in so it is on
                        // dp_row in the very first ISSUE cycle.
                        dp_row_q    <= m_in_row[0];
                        dp_valid_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // issue_idx_q names the row currently on dp_row.
                    if (issue_idx_q == LAST_IDX) begin
                        dp_row_q   <= '0;
                        dp_valid_q <= 1'b0;
                        state_q    <= S_DRAIN;
                    end else begin
                        issue_idx_q <= issue_idx_q + IDX_W'(1);
                        dp_row_q    <= shadow_q[issue_idx_q + IDX_W'(1)];
                    end
                end

                S_DRAIN: begin
                    // With DP_LAT >= 1 the last capture always falls after
                    // the last issue, so it is only ever seen here.
                    if (cap_en && (cap_idx_q == LAST_IDX)) begin
                        m_out_q <= res_merged;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dp_row   = dp_row_q;
    assign dp_valid = dp_valid_q;
    assign m_out    = m_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_opp_m_ctrl.sv
// ---------------------------------------------------------------------------
// tb_opp_m_ctrl
//
// Drives two controllers from shared stimulus: one with a 1-cycle negating
// row datapath, one with a 3-stage pipelined version of the same datapath.
// Each directed step records per-cycle outputs and compares them with
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_opp_m_ctrl;

    localparam int ROWS  = 5;
    localparam int ROW_W = 40;
    localparam int MW    = ROWS * ROW_W;
    localparam int NC    = 24;

    // Row [1,3,2,5,0] and its negation.
    localparam logic [ROW_W-1:0] ROW_A = 40'h0103020500;
    localparam logic [ROW_W-1:0] NEG_A = 40'hFFFDFEFB00;
    localparam logic [MW-1:0]    MAT_A = {5{ROW_A}};
    localparam logic [MW-1:0]    OUT_A = {5{NEG_A}};
    // Row r = [-1-r,-3,-2,-5,0]; result row r = [1+r,3,2,5,0].
    localparam logic [MW-1:0] MAT_B = {40'hFFFDFEFB00, 40'hFEFDFEFB00,
                                       40'hFDFDFEFB00, 40'hFCFDFEFB00,
                                       40'hFBFDFEFB00};
    localparam logic [MW-1:0] OUT_B = {40'h0103020500, 40'h0203020500,
                                       40'h0303020500, 40'h0403020500,
                                       40'h0503020500};

    logic             clk;
    logic             rst;
    logic             start;
    logic [MW-1:0]    m_in;
    logic [ROW_W-1:0] dp_row1, dp_res1, dp_row3, dp_res3, p3_a, p3_b;
    logic             dp_valid1, busy1, done1;
    logic             dp_valid3, busy3, done3;
    logic [MW-1:0]    m_out1, m_out3;

    int checks = 0;
    int errors = 0;

    logic [NC-1:0]    vld1_v, dn1_v, bsy1_v, vld3_v, dn3_v, bsy3_v;
    logic [MW-1:0]    mo_mid1;
    logic [ROW_W-1:0] row_c1, row_c5, row_c6;
    logic             any_done;

    opp_m_ctrl #(.ROWS(ROWS), .ROW_W(ROW_W), .DP_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .m_in(m_in),
        .dp_row(dp_row1), .dp_valid(dp_valid1), .dp_res(dp_res1),
        .m_out(m_out1), .busy(busy1), .done(done1)
    );

    opp_m_ctrl #(.ROWS(ROWS), .ROW_W(ROW_W), .DP_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .m_in(m_in),
        .dp_row(dp_row3), .dp_valid(dp_valid3), .dp_res(dp_res3),
        .m_out(m_out3), .busy(busy3), .done(done3)
    );

    // Row datapath model: negate each signed 8-bit element.
    function automatic logic [ROW_W-1:0] neg_row(input logic [ROW_W-1:0] r);
        logic [ROW_W-1:0] o;
        for (int i = 0; i < 5; i++) begin
            o[i*8 +: 8] = 8'd0 - r[i*8 +: 8];
        end
        return o;
    endfunction

    always @(posedge clk) begin
        dp_res1 <= neg_row(dp_row1);
        p3_a    <= neg_row(dp_row3);
        p3_b    <= p3_a;
        dp_res3 <= p3_b;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [MW-1:0] obs,
                       input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs NC cycles. Cycle c's inputs are driven just after the previous
    // edge and the registered outputs of cycle c are sampled alongside.
    task automatic run_op(input logic [NC-1:0] smask, input logic [MW-1:0] mat,
                          input bit chg2);
        m_in = mat;
        for (int c = 0; c < NC; c++) begin
            start = smask[c];
            if (chg2 && c == 2) m_in = '0;
            vld1_v[c] = dp_valid1;
            dn1_v[c]  = done1;
            bsy1_v[c] = busy1;
            vld3_v[c] = dp_valid3;
            dn3_v[c]  = done3;
            bsy3_v[c] = busy3;
            if (c == 1) row_c1 = dp_row1;
            if (c == 5) row_c5 = dp_row1;
            if (c == 6) begin
                row_c6  = dp_row1;
                mo_mid1 = m_out1;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic chk_timing(input string name);
        chk({name, ".vld1"}, MW'(vld1_v), MW'(24'h00003E));
        chk({name, ".done1"}, MW'(dn1_v), MW'(24'h000080));
        chk({name, ".busy1"}, MW'(bsy1_v), MW'(24'h00007E));
        chk({name, ".vld3"}, MW'(vld3_v), MW'(24'h00003E));
        chk({name, ".done3"}, MW'(dn3_v), MW'(24'h000200));
        chk({name, ".busy3"}, MW'(bsy3_v), MW'(24'h0001FE));
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        m_in  = '0;
        any_done = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.dp_valid", MW'(dp_valid1), MW'(1'b0));
        chk("rst.dp_row", MW'(dp_row1), '0);
        chk("rst.busy", MW'(busy1), MW'(1'b0));
        chk("rst.done", MW'(done1), MW'(1'b0));
        chk("rst.m_out1", m_out1, '0);
        chk("rst.m_out3", m_out3, '0);
        rst = 1'b1;
        tick();
        $display("step reset: checks=%0d errors=%0d", checks, errors);

        // Positive row values
        run_op(24'h000001, MAT_A, 1'b0);
        chk_timing("pos");
        chk("pos.row_c1", MW'(row_c1), MW'(ROW_A));
        chk("pos.row_c6", MW'(row_c6), '0);
        chk("pos.m_out_mid", mo_mid1, '0);
        chk("pos.m_out1", m_out1, OUT_A);
        chk("pos.m_out3", m_out3, OUT_A);
        $display("step positive: checks=%0d errors=%0d", checks, errors);

        // Negative values, row ordering, hold between operations
        run_op(24'h000001, MAT_B, 1'b0);
        chk_timing("neg");
        chk("neg.row0_first", MW'(row_c1), MW'(40'hFFFDFEFB00));
        chk("neg.row4_last", MW'(row_c5), MW'(40'hFBFDFEFB00));
        chk("neg.m_out_hold", mo_mid1, OUT_A);
        chk("neg.m_out1", m_out1, OUT_B);
        chk("neg.m_out3", m_out3, OUT_B);
        $display("step negative: checks=%0d errors=%0d", checks, errors);

        // Start pulses while busy are ignored
        run_op(24'h000015, MAT_A, 1'b0);
        chk_timing("busy_start");
        chk("busy_start.m_out1", m_out1, OUT_A);
        chk("busy_start.m_out3", m_out3, OUT_A);
        $display("step busy_start: checks=%0d errors=%0d", checks, errors);

        // Input change after the start edge
        run_op(24'h000001, MAT_B, 1'b1);
        chk_timing("in_chg");
        chk("in_chg.m_out1", m_out1, OUT_B);
        chk("in_chg.m_out3", m_out3, OUT_B);
        $display("step input_change: checks=%0d errors=%0d", checks, errors);

        // Start held high: back-to-back operations
        run_op(24'hFFFFFF, MAT_A, 1'b0);
        chk("b2b.done1", MW'(dn1_v), MW'(24'h808080));
        chk("b2b.done3", MW'(dn3_v), MW'(24'h080200));
        chk("b2b.vld1", MW'(vld1_v), MW'(24'h3E3E3E));
        repeat (12) tick();
        chk("b2b.m_out1", m_out1, OUT_A);
        chk("b2b.m_out3", m_out3, OUT_A);
        chk("b2b.idle_busy3", MW'(busy3), MW'(1'b0));
        $display("step back_to_back: checks=%0d errors=%0d", checks, errors);

        // Reset in the middle of an operation
        m_in  = MAT_B;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("mid_rst.dp_valid1", MW'(dp_valid1), MW'(1'b0));
        chk("mid_rst.dp_row1", MW'(dp_row1), '0);
        chk("mid_rst.busy1", MW'(busy1), MW'(1'b0));
        chk("mid_rst.m_out1", m_out1, '0);
        chk("mid_rst.dp_valid3", MW'(dp_valid3), MW'(1'b0));
        chk("mid_rst.busy3", MW'(busy3), MW'(1'b0));
        chk("mid_rst.m_out3", m_out3, '0);
        for (int c = 0; c < 3; c++) begin
            any_done = any_done | done1 | done3;
            tick();
        end
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            any_done = any_done | done1 | done3;
            tick();
        end
        chk("mid_rst.no_done", MW'(any_done), MW'(1'b0));
        chk("mid_rst.m_out1_after", m_out1, '0);
        $display("step mid_reset: checks=%0d errors=%0d", checks, errors);

        // Restart after reset release
        run_op(24'h000001, MAT_B, 1'b0);
        chk_timing("restart");
        chk("restart.m_out1", m_out1, OUT_B);
        chk("restart.m_out3", m_out3, OUT_B);
        $display("step restart: checks=%0d errors=%0d", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
